seq_magnitude_comparator: RTL
=============================

# seq_magnitude_comparator

Parametrised, multi-cycle magnitude comparator for WIDTH-bit operands, unsigned or two's-complement. Operands are captured on a start pulse and compared DIGIT bits per cycle, MSB slice first, under a small FSM. The result is reported on the y0/y1/y2 flags with a one-cycle done pulse. It replaces the fixed 2-bit combinational comparator wherever wide operands must be compared without a long combinational carry chain.

## Interface
- WIDTH, 8 — operand width in bits; must be ≥ 2 and a multiple of DIGIT.
- DIGIT, 2 — bits compared per cycle; N = WIDTH/DIGIT slices.
- clk  in  1  — clock; all state changes on the rising edge.
- rst_n  in  1  — reset; one clock, reset asynchronous and active-low.
- start  in  1  — request; sampled only in IDLE.
- signed_mode  in  1  — 1 = two's-complement compare, 0 = unsigned; captured with the operands.
- a  in  WIDTH  — operand A; captured when start is accepted.
- b  in  WIDTH  — operand B; captured when start is accepted.
- busy  out  1  — high while in RUN.
- done  out  1  — one-cycle pulse when a result is valid.
- y0  out  1  — A < B.
- y1  out  1  — A == B.
- y2  out  1  — A > B.

## Operation
- **States:** IDLE, RUN, DONE.
  - IDLE → RUN on an edge with start=1. That edge registers a, b and signed_mode, and sets the slice index to N-1.
  - RUN: each edge compares slice [idx*DIGIT +: DIGIT] of the captured operands.
    - Slices differ (early exit enabled): register the result, go to DONE.
    - Slices equal and idx==0: register y1=1, go to DONE.
    - Otherwise: decrement idx.
  - DONE → IDLE unconditionally after one cycle.
- **Signed mode:** the sign bit (bit WIDTH-1) of both captured operands is inverted before comparison, which gives an offset-binary order. All other slices compare unsigned.
- **Outputs:**
  - Exactly one of y0/y1/y2 is high after any completed compare.
  - The flags update only on the edge entering DONE and hold until the next entry to DONE.
  - New a/b/start values do not disturb them.
- **Ignored start:** start in RUN or DONE is ignored, not queued. Operand inputs changing during RUN have no effect.

## Timing
- **Reset values:** busy=0, done=0, y0=0, y1=0, y2=0, state=IDLE. All flags zero means no result yet.
- **Reset mid-operation:** asserting rst_n low in RUN or DONE aborts immediately. No done pulse is emitted and all outputs return to 0.
- **Edge numbering:** start is accepted at edge 0 and the first slice compare occurs at edge 1.
- **Latency:**
  - Result after k compare edges, where k is the 1-based position of the first differing slice from the MSB, or N if the operands are equal.
  - done and the new flags are visible from edge k to edge k+1; busy is high from edge 0 to edge k.
  - Next start is accepted at the earliest at edge k+2 (IDLE).
- **Worst case:** latency of N compare cycles, so the throughput limit is N+2 cycles per compare.

## Configuration
- **COMPARATOR_EARLY_EXIT_EN defined:** RUN terminates at the first differing slice, giving variable latency k (1..N).
- **Not defined:**
  - RUN always executes all N slice compares.
  - The first difference is latched and later slices are ignored for the result.
  - done always asserts at edge N, giving constant latency.
- Functional result (y0/y1/y2) is identical in both builds.

## Test plan
All scenarios use WIDTH=8, DIGIT=2.
- **Reset state:** reset released → busy=0, done=0, y0=y1=y2=0.
- **Early-exit unsigned:** macro defined, unsigned, a=0x80, b=0x7F, start at edge 0 → y2=1, y0=y1=0, done pulse after edge 1, busy high edges 0–1 only.
- **Equal operands:** a=0x5A, b=0x5A → y1=1 with done after edge 4 (either build). Then a/b change in IDLE → flags unchanged.
- **Signed mode:** signed_mode=1, a=0x80 (-128), b=0x01 → y0=1. Same operands with signed_mode=0 → y2=1.
- **Constant latency:** macro undefined, a=0x80, b=0x7F → done after edge 4 (not 1), y2=1. Start pulsed at edge 2 during RUN → ignored, exactly one done pulse.
- **Reset abort:** start a=0x01, b=0x02, then rst_n low at edge 2 → busy=0, no done pulse, flags 0. A new start after release completes normally with y0=1.

Source files
------------

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle WIDTH-bit magnitude comparator, DIGIT bits per cycle, MSB slice first.
// Define COMPARATOR_EARLY_EXIT_EN to stop at the first differing slice (variable latency).
module seq_magnitude_comparator #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             y0,
  output logic             y1,
  output logic             y2
);

  localparam int unsigned N    = WIDTH / DIGIT;
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              y0_q, y0_d;
  logic              y1_q, y1_d;
  logic              y2_q, y2_d;

  logic [DIGIT-1:0]  slice_a;
  logic [DIGIT-1:0]  slice_b;
  logic              slice_ne;
  logic              slice_gt;
  logic              last_slice;

`ifndef COMPARATOR_EARLY_EXIT_EN
  // First difference seen so far, and its direction; later slices cannot override it.
  logic              diff_q, diff_d;
  logic              gt_q, gt_d;
  logic              res_ne;
  logic              res_gt;
`endif

  always_comb begin
    slice_a = '0;
    slice_b = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (idx_q == IdxW'(i)) begin
        slice_a = a_q[i*DIGIT +: DIGIT];
        slice_b = b_q[i*DIGIT +: DIGIT];
      end
    end
  end

  assign slice_ne   = (slice_a != slice_b);
  assign slice_gt   = (slice_a > slice_b);
  assign last_slice = (idx_q == '0);

`ifndef COMPARATOR_EARLY_EXIT_EN
  assign res_ne = diff_q | slice_ne;
  assign res_gt = diff_q ? gt_q : slice_gt;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    y0_d    = y0_q;
    y1_d    = y1_q;
    y2_d    = y2_q;
`ifndef COMPARATOR_EARLY_EXIT_EN
    diff_d  = diff_q;
    gt_d    = gt_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (start) begin
          // Flipping the sign bit maps two's-complement order onto unsigned order.
          a_d     = {a[WIDTH-1] ^ signed_mode, a[WIDTH-2:0]};
          b_d     = {b[WIDTH-1] ^ signed_mode, b[WIDTH-2:0]};
          idx_d   = IdxW'(N - 1);
          state_d = StRun;
`ifndef COMPARATOR_EARLY_EXIT_EN
          diff_d  = 1'b0;
          gt_d    = 1'b0;
`endif
        end
      end

      StRun: begin
`ifdef COMPARATOR_EARLY_EXIT_EN
        if (slice_ne) begin
          y0_d    = ~slice_gt;
          y1_d    = 1'b0;
          y2_d    = slice_gt;
          state_d = StDone;
        end else if (last_slice) begin
          y0_d    = 1'b0;
          y1_d    = 1'b1;
          y2_d    = 1'b0;
          state_d = StDone;
        end else begin
          idx_d = idx_q - IdxW'(1);
        end
`else
        if (last_slice) begin
          y0_d    = res_ne & ~res_gt;
          y1_d    = ~res_ne;
          y2_d    = res_ne & res_gt;
          state_d = StDone;
        end else begin
          idx_d = idx_q - IdxW'(1);
          if (!diff_q && slice_ne) begin
            diff_d = 1'b1;
            gt_d   = slice_gt;
          end
        end
`endif
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      y0_q    <= 1'b0;
      y1_q    <= 1'b0;
      y2_q    <= 1'b0;
`ifndef COMPARATOR_EARLY_EXIT_EN
      diff_q  <= 1'b0;
      gt_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      y0_q    <= y0_d;
      y1_q    <= y1_d;
      y2_q    <= y2_d;
`ifndef COMPARATOR_EARLY_EXIT_EN
      diff_q  <= diff_d;
      gt_q    <= gt_d;
`endif
    end
  end

  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);
  assign y0   = y0_q;
  assign y1   = y1_q;
  assign y2   = y2_q;

endmodule
